// File: rtl/sigmoid_arbiter.sv
// Round-robin arbiter that shares one sigmoid ROM among a layer's neurons.
// It saturates the granted sum into a ROM index and captures the ROM word into per-neuron activation registers.
module sigmoid_arbiter #(
    parameter int numNeurons = 4,
    parameter int sumWidth   = 16,
    parameter int inWidth    = 5,
    parameter int dataWidth  = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            layer_start,
    input  logic [numNeurons-1:0]           req,
    input  logic [numNeurons*sumWidth-1:0]  sum_in,
    output logic [numNeurons-1:0]           ack,
    output logic                            rom_val,
    output logic [inWidth-1:0]              rom_in,
    input  logic [dataWidth-1:0]            rom_out,
    output logic [numNeurons*dataWidth-1:0] act_out,
    output logic [numNeurons-1:0]           act_valid,
    output logic                            layer_done,
    output logic                            busy
);
    localparam int PtrW = (numNeurons > 1) ? $clog2(numNeurons) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t                r_state;
    logic [PtrW-1:0]       r_ptr;
    logic [numNeurons-1:0] r_ack;
    logic [numNeurons-1:0] r_act_valid;
    logic                  r_rom_val;
    logic [inWidth-1:0]    r_rom_in;
    logic [PtrW-1:0]       r_gnt_idx;
    logic                  r_cap_val;
    logic [PtrW-1:0]       r_cap_idx;
    logic                  r_layer_done;
    logic [dataWidth-1:0]  r_act [numNeurons];

    logic [numNeurons-1:0] w_in_flight;
    logic [numNeurons-1:0] w_eligible;
    logic [numNeurons-1:0] w_valid_next;
    logic [PtrW:0]         w_pos;
    logic                  w_gnt_found;
    logic [PtrW-1:0]       w_gnt_idx;
    logic [inWidth-1:0]    w_sat [numNeurons];

    // Clamp a signed sum into the signed ROM index range.
    function automatic logic [inWidth-1:0] saturate(input logic signed [sumWidth-1:0] s);
        logic signed [sumWidth-1:0] max_v;
        logic signed [sumWidth-1:0] min_v;
        max_v = sumWidth'((1 << (inWidth - 1)) - 1);
        min_v = ~max_v;
        if (s > max_v)      return max_v[inWidth-1:0];
        else if (s < min_v) return min_v[inWidth-1:0];
        else                return s[inWidth-1:0];
    endfunction

    for (genvar g = 0; g < numNeurons; g++) begin : g_lane
        assign w_sat[g] = saturate(sum_in[g*sumWidth +: sumWidth]);
        assign act_out[g*dataWidth +: dataWidth] = r_act[g];
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_in_flight  = '0;
        w_valid_next = r_act_valid;
        for (int i = 0; i < numNeurons; i++) begin
            w_in_flight[i] = (r_rom_val && r_gnt_idx == PtrW'(i)) ||
                             (r_cap_val && r_cap_idx == PtrW'(i));
        end
        if (r_cap_val) w_valid_next[r_cap_idx] = 1'b1;
    end

    assign w_eligible = req & ~r_act_valid & ~w_in_flight & ~r_ack;

    // Search starts at the pointer and wraps, so the first hit is the round-robin winner.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_pos       = '0;
        for (int off = 0; off < numNeurons; off++) begin
            w_pos = {1'b0, r_ptr} + (PtrW+1)'(off);
            if (w_pos >= (PtrW+1)'(numNeurons)) w_pos = w_pos - (PtrW+1)'(numNeurons);
            if (!w_gnt_found && w_eligible[w_pos[PtrW-1:0]]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_pos[PtrW-1:0];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_ack        <= '0;
            r_act_valid  <= '0;
            r_rom_val    <= 1'b0;
            r_rom_in     <= '0;
            r_gnt_idx    <= '0;
            r_cap_val    <= 1'b0;
            r_cap_idx    <= '0;
            r_layer_done <= 1'b0;
            // NOTE: the activation registers are architecturally visible, so they are reset too.
            for (int i = 0; i < numNeurons; i++) r_act[i] <= '0;
        end else if (layer_start) begin
            // A new pass flushes the pipeline; a capture landing on this edge is dropped.
            r_state      <= COLLECT;
            r_ptr        <= '0;
            r_ack        <= '0;
            r_act_valid  <= '0;
            r_rom_val    <= 1'b0;
            r_cap_val    <= 1'b0;
            r_layer_done <= 1'b0;
        end else begin
            r_ack        <= '0;
            r_rom_val    <= 1'b0;
            r_layer_done <= 1'b0;
            r_cap_val    <= r_rom_val;
            r_cap_idx    <= r_gnt_idx;
            r_act_valid  <= w_valid_next;
            if (r_cap_val) r_act[r_cap_idx] <= rom_out;

            if (r_state == COLLECT) begin
                if (w_gnt_found) begin
                    r_ack[w_gnt_idx] <= 1'b1;
                    r_rom_val        <= 1'b1;
                    r_rom_in         <= w_sat[w_gnt_idx];
                    r_gnt_idx        <= w_gnt_idx;
                    r_ptr            <= (w_gnt_idx == PtrW'(numNeurons - 1)) ? '0 : w_gnt_idx + 1'b1;
                end
                if (&w_valid_next) begin
                    r_state      <= DONE;
                    r_layer_done <= 1'b1;
                end
            end
        end
    end

    assign ack        = r_ack;
    assign rom_val    = r_rom_val;
    assign rom_in     = r_rom_in;
    assign act_valid  = r_act_valid;
    assign layer_done = r_layer_done;
    assign busy       = (r_state == COLLECT);

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Self-checking bench for sigmoid_arbiter: directed scenarios plus randomized passes,
// checked every cycle against a grant-order / served-set model of the layer pass.
module tb_sigmoid_arbiter;
    localparam int NN = 4;
    localparam int SW = 16;
    localparam int IW = 5;
    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 layer_start;
    logic [NN-1:0]        req;
    logic [NN*SW-1:0]     sum_in;
    logic [NN-1:0]        ack;
    logic                 rom_val;
    logic [IW-1:0]        rom_in;
    logic [DW-1:0]        rom_out = '0;
    logic [NN*DW-1:0]     act_out;
    logic [NN-1:0]        act_valid;
    logic                 layer_done;
    logic                 busy;

    logic signed [SW-1:0] sums [NN];

    int total = 0;
    int bad   = 0;

    sigmoid_arbiter #(
        .numNeurons(NN), .sumWidth(SW), .inWidth(IW), .dataWidth(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .layer_start(layer_start), .req(req),
        .sum_in(sum_in), .ack(ack), .rom_val(rom_val), .rom_in(rom_in),
        .rom_out(rom_out), .act_out(act_out), .act_valid(act_valid),
        .layer_done(layer_done), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NN; i++) sum_in[i*SW +: SW] = sums[i];
    end

    // Stand-in sigmoid ROM: distinct word per index, one cycle read latency.
    function automatic logic [DW-1:0] rom_f(input logic [IW-1:0] x);
        return {x, 3'b101, ~x, x[2:0]};
    endfunction

    always @(posedge clk) if (rom_val) rom_out <= rom_f(rom_in);

    function automatic logic [IW-1:0] sat(input int s);
        int hi;
        int lo;
        int r;
        hi = (1 << (IW - 1)) - 1;
        lo = -(1 << (IW - 1));
        r  = (s > hi) ? hi : ((s < lo) ? lo : s);
        return r[IW-1:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a pass is a served set plus a pointer; each grant's result lands two edges later.
    bit            m_collect = 1'b0;
    logic [NN-1:0] m_served  = '0;
    logic [NN-1:0] m_valid   = '0;
    int            m_ptr     = 0;
    logic [DW-1:0] m_act [NN];
    int            due [NN];
    logic [DW-1:0] due_val [NN];
    int            edge_n    = 0;
    logic [NN-1:0] e_ack     = '0;
    bit            e_rom_val = 1'b0;
    logic [IW-1:0] e_rom_in  = '0;
    bit            e_ld      = 1'b0;

    function automatic logic [NN*DW-1:0] packed_act();
        logic [NN*DW-1:0] p;
        for (int i = 0; i < NN; i++) p[i*DW +: DW] = m_act[i];
        return p;
    endfunction

    task automatic model_edge();
        bit            was_collect;
        int            g;
        int            c;
        logic [IW-1:0] idx;
        edge_n++;
        if (!rst_n) begin
            m_collect = 1'b0; m_served = '0; m_valid = '0; m_ptr = 0;
            e_ack = '0; e_rom_val = 1'b0; e_rom_in = '0; e_ld = 1'b0;
            for (int i = 0; i < NN; i++) begin m_act[i] = '0; due[i] = -1; end
        end else if (layer_start) begin
            m_collect = 1'b1; m_served = '0; m_valid = '0; m_ptr = 0;
            e_ack = '0; e_rom_val = 1'b0; e_ld = 1'b0;
            for (int i = 0; i < NN; i++) due[i] = -1;
        end else begin
            was_collect = m_collect;
            e_ack = '0; e_rom_val = 1'b0; e_ld = 1'b0;
            for (int i = 0; i < NN; i++) begin
                if (due[i] == edge_n) begin
                    m_act[i] = due_val[i]; m_valid[i] = 1'b1; due[i] = -1;
                end
            end
            if (was_collect) begin
                g = -1;
                for (int k = 0; k < NN; k++) begin
                    c = (m_ptr + k) % NN;
                    if (g < 0 && req[c] && !m_served[c]) g = c;
                end
                if (g >= 0) begin
                    idx = sat(int'(sums[g]));
                    m_served[g] = 1'b1; e_ack[g] = 1'b1; e_rom_val = 1'b1; e_rom_in = idx;
                    due[g] = edge_n + 2; due_val[g] = rom_f(idx);
                    m_ptr = (g + 1) % NN;
                end
                if (m_valid == '1) begin m_collect = 1'b0; e_ld = 1'b1; end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check("ack", ack, e_ack);
        check("rom_val", rom_val, e_rom_val);
        check("rom_in", rom_in, e_rom_in);
        check("act_valid", act_valid, m_valid);
        check("act_out", act_out, packed_act());
        check("layer_done", layer_done, e_ld);
        check("busy", busy, m_collect);
    endtask

    task automatic start_pass();
        layer_start = 1'b1;
        step();
        layer_start = 1'b0;
    endtask

    int            order [$];
    int            ld_cnt;
    int            arrive [NN];
    bit            drop [NN];
    int            vals [3]  = '{37, -100, -3};
    logic [IW-1:0] sexp [3]  = '{5'd15, 5'b10000, 5'b11101};
    logic [NN-1:0] fair_req;

    initial begin
        for (int i = 0; i < NN; i++) begin m_act[i] = '0; due[i] = -1; sums[i] = '0; end

        // Reset held with every input active, then IDLE ignores requests.
        rst_n = 1'b0; layer_start = 1'b1; req = '1;
        repeat (3) step();
        check("rst_ack", ack, '0);
        rst_n = 1'b1; layer_start = 1'b0;
        repeat (3) step();
        check("idle_no_ack", ack, '0);

        // Saturation and capture latency on neuron 0.
        for (int t = 0; t < 3; t++) begin
            req = '0;
            start_pass();
            sums[0] = SW'(vals[t]);
            req = 4'b0001;
            step();
            check("sat_ack", ack, 4'b0001);
            check("sat_rom_in", rom_in, sexp[t]);
            req = '0;
            step();
            step();
            check("sat_act0", act_out[DW-1:0], rom_f(sexp[t]));
        end

        // Fairness with all requests together, held through DONE.
        req = '0;
        start_pass();
        for (int i = 0; i < NN; i++) sums[i] = SW'($urandom_range(0, 60)) - SW'(30);
        fair_req = '1;
        req = fair_req;
        order.delete(); ld_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            for (int i = 0; i < NN; i++) if (ack[i]) order.push_back(i);
            if (layer_done) ld_cnt++;
        end
        check("fair_count", order.size(), NN);
        for (int k = 0; k < NN; k++) check("fair_order", (k < order.size()) ? order[k] : -1, k);
        check("done_pulses", ld_cnt, 1);
        check("busy_after_done", busy, 1'b0);

        // Wrap-around: neuron 2 first, then 0, 1, 3 together -> 3, 0, 1.
        req = '0;
        start_pass();
        req = 4'b0100;
        step();
        req = 4'b1011;
        order.delete();
        for (int c = 0; c < 8; c++) begin
            step();
            for (int i = 0; i < NN; i++) if (ack[i]) order.push_back(i);
        end
        check("wrap_count", order.size(), 3);
        check("wrap_0", (order.size() > 0) ? order[0] : -1, 3);
        check("wrap_1", (order.size() > 1) ? order[1] : -1, 0);
        check("wrap_2", (order.size() > 2) ? order[2] : -1, 1);

        // Restart on the edge that would capture neuron 1.
        req = '0;
        start_pass();
        req = '1;
        repeat (3) step();
        layer_start = 1'b1;
        step();
        layer_start = 1'b0;
        check("flush_valid", act_valid, '0);
        step();
        check("flush_regrant0", ack, 4'b0001);
        step();
        check("flush_regrant1", ack, 4'b0010);
        repeat (6) step();

        // Reset in the middle of a pass.
        req = '1;
        start_pass();
        repeat (3) step();
        rst_n = 1'b0;
        step();
        check("rst_mid_valid", act_valid, '0);
        check("rst_mid_act", act_out, '0);
        check("rst_mid_busy", busy, 1'b0);
        rst_n = 1'b1; req = '0;
        step();

        // Randomized passes: staggered arrivals, optional drop after ack, rare mid-pass restart.
        for (int p = 0; p < 24; p++) begin
            req = '0;
            start_pass();
            for (int i = 0; i < NN; i++) begin
                arrive[i] = $urandom_range(0, 6);
                drop[i]   = bit'($urandom_range(0, 1));
                sums[i]   = $urandom_range(0, 1) ? SW'($urandom) : SW'($urandom_range(0, 40)) - SW'(20);
            end
            for (int c = 0; c < 20; c++) begin
                for (int i = 0; i < NN; i++) if (c == arrive[i] && !m_served[i]) req[i] = 1'b1;
                layer_start = ($urandom_range(0, 39) == 0);
                step();
                layer_start = 1'b0;
                for (int i = 0; i < NN; i++) if (e_ack[i] && drop[i]) req[i] = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
